multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM sequencing the shared RV32I datapath (one ALU, one unified memory port) over several cycles
//  per instruction. Sits between the instruction register (op/funct3), ALU flags and the memory handshake.
//  Drives every datapath enable and mux select. Stretches memory states until mem_ready.
// PARAMETERS
//  ILLEGAL_HALT  1   1: unknown opcode -> HALT (sticky until reset); 0: skip, return to FETCH
//  CNT_W         32  width of performance counters
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  op         in   7      IR[6:0], held stable by IR after FETCH
//  funct3     in   3      IR[14:12]
//  Zero       in   1      ALU result == 0
//  ALUR31     in   1      ALU result bit 31
//  mem_ready  in   1      memory completes the requested access this cycle
//  mem_req    out  1      memory access request, held until mem_ready
//  AdrSrc     out  1      0 = PC, 1 = ALUOut
//  MemWrite   out  1      store strobe, valid with mem_req
//  IRWrite    out  1      load IR and OldPC
//  PCWrite    out  1      PC <- Result
//  RegWrite   out  1      register file write
//  ResultSrc  out  2      00 ALUOut, 01 ReadData, 10 ALUResult, 11 U-immediate path
//  ALUSrcA    out  2      00 PC, 01 OldPC, 10 rs1
//  ALUSrcB    out  2      00 rs2, 01 ImmExt, 10 constant 4
//  ALUOp      out  2      00 add, 01 subtract/compare, 10 decode by funct
//  ImmSrc     out  2      combinational from op: 00 I/lw/jalr/other, 01 sw, 10 branch, 11 jal
//  illegal    out  1      one-cycle pulse in DECODE on an unknown opcode
//  cycle_cnt  out  CNT_W  cycles since reset (0 when PERF_CNT_EN is not defined)
//  instret    out  CNT_W  retired instructions (0 when PERF_CNT_EN is not defined)
// BEHAVIOUR
//  - reset: state <= FETCH; all outputs forced 0 in any cycle with reset=1. This includes mem_req,
//    gated combinationally. Reset during a pending access abandons it. The first FETCH request is in the
//    first cycle after reset deasserts.
//  - Outputs not listed in a state are 0.
//  - FETCH: mem_req, AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10. Holds until mem_ready.
//    In the mem_ready cycle: IRWrite=1, PCWrite=1, then -> DECODE.
//  - DECODE: SrcA=01, SrcB=01, ALUOp=00 (branch/jal target -> ALUOut). Next state by op:
//    lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; branch -> BRANCH; jal -> JAL; jalr -> JALR;
//    lui/auipc (0?10111) -> UPPER; otherwise illegal=1 and -> HALT or FETCH per ILLEGAL_HALT.
//  - MEMADR: SrcA=10, SrcB=01, ALUOp=00. -> MEMREAD (lw) or MEMWRITE (sw).
//  - MEMREAD: mem_req, AdrSrc=1; on mem_ready -> MEMWB. MEMWB: ResultSrc=01, RegWrite -> FETCH.
//  - MEMWRITE: mem_req, AdrSrc=1, MemWrite held; on mem_ready -> FETCH.
//  - EXECR: SrcA=10, SrcB=00, ALUOp=10 -> ALUWB. EXECI: SrcA=10, SrcB=01, ALUOp=10 -> ALUWB.
//    ALUWB: ResultSrc=00, RegWrite -> FETCH.
//  - BRANCH: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, PCWrite=take -> FETCH.
//    take: funct3 000 = Zero, 001 = !Zero, 101 = !ALUR31, any other funct3 = 0.
//  - JALR: SrcA=10, SrcB=01, ALUOp=00 -> JAL.
//    JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCWrite -> ALUWB (rd <- OldPC+4).
//  - UPPER: ResultSrc=11, RegWrite -> FETCH. HALT: all outputs 0; leaves only on reset.
//  - mem_ready is ignored when mem_req=0. mem_ready in the first request cycle gives a zero-wait access.
//  - Zero-wait latency in cycles: branch/lui 3, R/I/sw/jal 4, lw/jalr 5; each memory wait cycle adds 1.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - cycle_cnt +1 every non-reset cycle.
//   - instret +1 on each cycle with next state = FETCH and current state not in {FETCH, HALT}.
//   - Both counters clear on reset and wrap 2^CNT_W-1 -> 0.
//  PERF_CNT_EN undefined: counter registers are not built; cycle_cnt and instret tie to 0.
// TESTING
//  1 reset=1 for 2 cycles with op=0110011 -> all outputs 0; after release mem_req=1 in the next cycle.
//  2 add (0110011), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; RegWrite only in cycle 4; instret=1.
//  3 lw, MEMREAD mem_ready late by 3 cycles -> mem_req and AdrSrc=1 for 4 cycles; RegWrite in MEMWB;
//    8 cycles total.
//  4 BRANCH state checks:
//    - bne (funct3=001), Zero=1 -> PCWrite=0; Zero=0 -> PCWrite=1.
//    - bge (funct3=101), ALUR31=1 -> PCWrite=0.
//  5 jalr (1100111) -> FETCH, DECODE, JALR, JAL, ALUWB; PCWrite in JAL, RegWrite in ALUWB.
//  6 op=0000000, ILLEGAL_HALT=1 -> illegal pulse 1 cycle, then mem_req=0 indefinitely; reset -> FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM (Moore). Sequences the shared ALU and the
// unified memory port over several cycles per instruction, stretching the
// memory states until mem_ready.
// Optional feature: define PERF_CNT_EN to build the cycle/retired counters;
// otherwise cycle_cnt and instret are tied to zero.
module multicycle_controller #(
  parameter int ILLEGAL_HALT = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             Zero,
  input  logic             ALUR31,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_UPPER, S_HALT
  } state_t;

  state_t state, nextState;

  // Raw (pre-reset-gating) control values
  logic       memReqR, adrSrcR, memWriteR, irWriteR, pcWriteR, regWriteR, illegalR;
  logic [1:0] resultSrcR, srcAR, srcBR, aluOpR, immSrcR;
  logic       take;

  // State register; reset abandons any pending access and restarts at FETCH
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nextState;
  end

  // Branch decision from ALU flags; unsupported compares never take
  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000:  take = Zero;
      3'b001:  take = ~Zero;
      3'b101:  take = ~ALUR31;
      default: take = 1'b0;
    endcase
  end

  // Immediate format selected straight from the opcode
  always_comb begin
    immSrcR = 2'b00;
    case (op)
      OP_SW:   immSrcR = 2'b01;
      OP_BR:   immSrcR = 2'b10;
      OP_JAL:  immSrcR = 2'b11;
      default: immSrcR = 2'b00;
    endcase
  end

  // Next state and per-state controls; anything not set stays 0
  always_comb begin
    nextState  = state;
    memReqR    = 1'b0;
    adrSrcR    = 1'b0;
    memWriteR  = 1'b0;
    irWriteR   = 1'b0;
    pcWriteR   = 1'b0;
    regWriteR  = 1'b0;
    illegalR   = 1'b0;
    resultSrcR = 2'b00;
    srcAR      = 2'b00;
    srcBR      = 2'b00;
    aluOpR     = 2'b00;
    case (state)
      S_FETCH: begin
        memReqR    = 1'b1;
        resultSrcR = 2'b10;
        srcBR      = 2'b10;
        if (mem_ready) begin
          irWriteR  = 1'b1;
          pcWriteR  = 1'b1;
          nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute branch/jal target into ALUOut while decoding
        srcAR = 2'b01;
        srcBR = 2'b01;
        casez (op)
          OP_LW, OP_SW: nextState = S_MEMADR;
          OP_R:         nextState = S_EXECR;
          OP_I:         nextState = S_EXECI;
          OP_BR:        nextState = S_BRANCH;
          OP_JAL:       nextState = S_JAL;
          OP_JALR:      nextState = S_JALR;
          7'b0?10111:   nextState = S_UPPER;
          default: begin
            illegalR  = 1'b1;
            nextState = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        srcAR     = 2'b10;
        srcBR     = 2'b01;
        nextState = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        memReqR = 1'b1;
        adrSrcR = 1'b1;
        if (mem_ready) nextState = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrcR = 2'b01;
        regWriteR  = 1'b1;
        nextState  = S_FETCH;
      end
      S_MEMWRITE: begin
        memReqR   = 1'b1;
        adrSrcR   = 1'b1;
        memWriteR = 1'b1;
        if (mem_ready) nextState = S_FETCH;
      end
      S_EXECR: begin
        srcAR     = 2'b10;
        aluOpR    = 2'b10;
        nextState = S_ALUWB;
      end
      S_EXECI: begin
        srcAR     = 2'b10;
        srcBR     = 2'b01;
        aluOpR    = 2'b10;
        nextState = S_ALUWB;
      end
      S_ALUWB: begin
        regWriteR = 1'b1;
        nextState = S_FETCH;
      end
      S_BRANCH: begin
        srcAR     = 2'b10;
        aluOpR    = 2'b01;
        pcWriteR  = take;
        nextState = S_FETCH;
      end
      S_JALR: begin
        // Target rs1+imm lands in ALUOut, then shares the JAL link path
        srcAR     = 2'b10;
        srcBR     = 2'b01;
        nextState = S_JAL;
      end
      S_JAL: begin
        srcAR     = 2'b01;
        srcBR     = 2'b10;
        pcWriteR  = 1'b1;
        nextState = S_ALUWB;
      end
      S_UPPER: begin
        resultSrcR = 2'b11;
        regWriteR  = 1'b1;
        nextState  = S_FETCH;
      end
      S_HALT:  nextState = S_HALT;
      default: nextState = S_FETCH;
    endcase
  end

  // Reset forces every output low combinationally, including the memory request
  assign mem_req   = reset ? 1'b0  : memReqR;
  assign AdrSrc    = reset ? 1'b0  : adrSrcR;
  assign MemWrite  = reset ? 1'b0  : memWriteR;
  assign IRWrite   = reset ? 1'b0  : irWriteR;
  assign PCWrite   = reset ? 1'b0  : pcWriteR;
  assign RegWrite  = reset ? 1'b0  : regWriteR;
  assign illegal   = reset ? 1'b0  : illegalR;
  assign ResultSrc = reset ? 2'b00 : resultSrcR;
  assign ALUSrcA   = reset ? 2'b00 : srcAR;
  assign ALUSrcB   = reset ? 2'b00 : srcBR;
  assign ALUOp     = reset ? 2'b00 : aluOpR;
  assign ImmSrc    = (reset || state == S_HALT) ? 2'b00 : immSrcR;

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] cycReg, retReg;
  logic             retire;

  // An instruction retires on its last state, i.e. the one heading back to FETCH
  assign retire = (nextState == S_FETCH) && (state != S_FETCH) && (state != S_HALT);

  // Free-running performance counters, wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      cycReg <= '0;
      retReg <= '0;
    end else begin
      cycReg <= cycReg + CNT_ONE;
      if (retire) retReg <= retReg + CNT_ONE;
    end
  end

  assign cycle_cnt = cycReg;
  assign instret   = retReg;
`else
  assign cycle_cnt = '0;
  assign instret   = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction pushes its
// expected per-cycle control vector and input stimulus; the drain loop
// applies stimulus and compares the DUT outputs cycle by cycle.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = 7'b0110011;
  logic [2:0]  funct3 = 3'b000;
  logic        Zero = 1'b0, ALUR31 = 1'b0, mem_ready = 1'b0;
  logic        mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [31:0] cycle_cnt, instret;

  multicycle_controller #(.ILLEGAL_HALT(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero),
    .ALUR31(ALUR31), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .illegal(illegal), .cycle_cnt(cycle_cnt), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mr;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic       r31;
  } stim_t;

  logic [16:0] expQ[$];
  stim_t       stimQ[$];
  int          nChecks = 0, nErrors = 0;
  int          retModel = 0;
  logic [31:0] cycModel;

  // {mem_req,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,ResultSrc,SrcA,SrcB,ALUOp,ImmSrc,illegal}
  wire [16:0] outVec = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                        ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};

  always @(posedge clk) begin
    if (reset) cycModel <= 32'd0;
    else       cycModel <= cycModel + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [1:0] immModel(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic takeModel(input logic [2:0] f3, input logic z, input logic r31);
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return !z;
    if (f3 == 3'b101) return !r31;
    return 1'b0;
  endfunction

  function automatic logic [16:0] mk(input logic mr, adr, mw, irw, pcw, rw,
                                     input logic [1:0] rs, sa, sb, aop, ims,
                                     input logic ill);
    return {mr, adr, mw, irw, pcw, rw, rs, sa, sb, aop, ims, ill};
  endfunction

  task automatic push(input logic [16:0] e, input logic mr, input logic [6:0] o,
                      input logic [2:0] f3, input logic z, input logic r31);
    stim_t s;
    s = '{mr: mr, op: o, f3: f3, z: z, r31: r31};
    expQ.push_back(e);
    stimQ.push_back(s);
  endtask

  // Expected cycle sequence for one instruction; fw/mw = memory wait cycles
  task automatic pushInstr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                           input logic r31, input int fw, input int mw);
    logic [1:0] ims;
    logic       rnd;
    bit         known;
    ims = immModel(o);
    known = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111) ||
            (o == 7'b1100111) || (o == 7'b0110111) || (o == 7'b0010111);
    for (int i = 0; i < fw; i++)
      push(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,ims,0), 1'b0, o, f3, z, r31);
    push(mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,ims,0), 1'b1, o, f3, z, r31);
    rnd = 1'($urandom_range(0, 1));
    push(mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,ims,!known), rnd, o, f3, z, r31);
    case (o)
      7'b0000011, 7'b0100011: begin
        rnd = 1'($urandom_range(0, 1));
        push(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,ims,0), rnd, o, f3, z, r31);
        for (int i = 0; i <= mw; i++)
          push(mk(1,1,o[5],0,0,0,2'b00,2'b00,2'b00,2'b00,ims,0), (i == mw), o, f3, z, r31);
        if (o == 7'b0000011)
          push(mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,ims,0), 1'b1, o, f3, z, r31);
      end
      7'b0110011, 7'b0010011: begin
        push(mk(0,0,0,0,0,0,2'b00,2'b10,(o[5] ? 2'b00 : 2'b01),2'b10,ims,0), 1'b1, o, f3, z, r31);
        push(mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,ims,0), 1'b1, o, f3, z, r31);
      end
      7'b1100011:
        push(mk(0,0,0,0,takeModel(f3,z,r31),0,2'b00,2'b10,2'b00,2'b01,ims,0), 1'b1, o, f3, z, r31);
      7'b1101111, 7'b1100111: begin
        if (o == 7'b1100111)
          push(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,ims,0), 1'b1, o, f3, z, r31);
        push(mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,ims,0), 1'b1, o, f3, z, r31);
        push(mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,ims,0), 1'b1, o, f3, z, r31);
      end
      7'b0110111, 7'b0010111:
        push(mk(0,0,0,0,0,1,2'b11,2'b00,2'b00,2'b00,ims,0), 1'b1, o, f3, z, r31);
      default:
        for (int i = 0; i < 6; i++) push(17'd0, 1'b1, o, f3, z, r31);
    endcase
    if (known) retModel++;
  endtask

  task automatic drain(input string tag);
    stim_t s;
    while (expQ.size() > 0) begin
      @(negedge clk);
      s = stimQ.pop_front();
      reset = 1'b0;
      mem_ready = s.mr; op = s.op; funct3 = s.f3; Zero = s.z; ALUR31 = s.r31;
      #2;
      chk(tag, outVec, expQ.pop_front());
    end
  endtask

  task automatic chkCounters(input string tag);
    logic [31:0] wantCyc, wantRet;
    @(posedge clk);
    #1;
    wantCyc = 32'd0;
    wantRet = 32'd0;
`ifdef PERF_CNT_EN
    wantCyc = cycModel;
    wantRet = 32'(retModel);
`endif
    chk({tag, "_cycle_cnt"}, cycle_cnt, wantCyc);
    chk({tag, "_instret"}, instret, wantRet);
  endtask

  task automatic doReset(input logic [6:0] o);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1; op = o; mem_ready = 1'b1; Zero = 1'b1;
      #2;
      chk("reset_outputs", outVec, 17'd0);
      if (i == 1) chk("reset_cycle_cnt", cycle_cnt, 32'd0);
    end
    retModel = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    doReset(7'b0110011);

    pushInstr(7'b0110011, 3'b000, 0, 0, 0, 0);   // add
    drain("add");
    chkCounters("add");

    pushInstr(7'b0000011, 3'b010, 0, 0, 0, 3);   // lw, read late by 3
    drain("lw");
    pushInstr(7'b0100011, 3'b010, 0, 0, 2, 1);   // sw, fetch and write waits
    pushInstr(7'b0010011, 3'b000, 0, 0, 0, 0);   // addi
    drain("sw_addi");

    pushInstr(7'b1100011, 3'b000, 1, 0, 0, 0);   // beq taken
    pushInstr(7'b1100011, 3'b001, 1, 0, 0, 0);   // bne not taken
    pushInstr(7'b1100011, 3'b001, 0, 0, 0, 0);   // bne taken
    pushInstr(7'b1100011, 3'b101, 0, 1, 0, 0);   // bge not taken
    pushInstr(7'b1100011, 3'b101, 0, 0, 1, 0);   // bge taken
    pushInstr(7'b1100011, 3'b100, 1, 1, 0, 0);   // blt unsupported -> never
    drain("branch");

    pushInstr(7'b1101111, 3'b000, 0, 0, 0, 0);   // jal
    pushInstr(7'b1100111, 3'b000, 0, 0, 0, 0);   // jalr
    pushInstr(7'b0110111, 3'b000, 0, 0, 0, 0);   // lui
    pushInstr(7'b0010111, 3'b000, 0, 0, 1, 0);   // auipc
    drain("jump_upper");
    chkCounters("mid");

    pushInstr(7'b0000000, 3'b000, 0, 0, 0, 0);   // illegal -> HALT
    drain("illegal_halt");
    chkCounters("halt");

    doReset(7'b0100011);
    pushInstr(7'b0110111, 3'b000, 0, 0, 0, 0);   // restart after reset
    drain("post_reset");
    chkCounters("end");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
